// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes from the ALU control decoder and
// the iterative mult/div sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MULT = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_DIV  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_MUL,
        MD_DIV,
        MD_FIX,
        MD_DONE
    } md_state_t;

    function automatic logic is_muldiv(input logic [3:0] con);
        return (con == ALU_MULT) || (con == ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative signed multiply (shift-add) / divide (restoring) on operand
// magnitudes, with a final sign-fix step and a one-state done handshake.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             idle_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    md_state_t        state_q, state_d;
    logic [WIDTH-1:0] acc_q, sh_q, mcand_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q, sa_q, is_div_q;

    logic             last_iter;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign last_iter = (cnt_q == CW'(WIDTH - 1));
    assign abs_a     = a_i[WIDTH-1] ? -a_i : a_i;
    assign abs_b     = b_i[WIDTH-1] ? -b_i : b_i;

    // {acc,sh} is the product register for mult; for div acc is the partial
    // remainder and sh shifts the dividend out while the quotient shifts in.
    assign mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mcand_q} : '0);
    assign div_shift = {acc_q, sh_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= MD_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (start_i) state_d = is_div_i ? MD_DIV : MD_MUL;
            MD_MUL:  if (last_iter) state_d = MD_FIX;
            MD_DIV: begin
                if (mcand_q == '0)  state_d = MD_DONE;
                else if (last_iter) state_d = MD_FIX;
            end
            MD_FIX:  state_d = MD_DONE;
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            sh_q     <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            case (state_q)
                MD_IDLE: if (start_i) begin
                    acc_q    <= '0;
                    sh_q     <= abs_a;
                    mcand_q  <= abs_b;
                    cnt_q    <= '0;
                    sa_q     <= a_i[WIDTH-1];
                    neg_q    <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
                    is_div_q <= is_div_i;
                end
                MD_MUL: begin
                    {acc_q, sh_q} <= {mul_sum, sh_q[WIDTH-1:1]};
                    cnt_q         <= cnt_q + CW'(1);
                end
                MD_DIV: begin
                    if (!div_diff[WIDTH]) begin
                        acc_q <= div_diff[WIDTH-1:0];
                        sh_q  <= {sh_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_q <= div_shift[WIDTH-1:0];
                        sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + CW'(1);
                end
                MD_FIX: begin
                    if (is_div_q) begin
                        if (neg_q) sh_q  <= -sh_q;
                        if (sa_q)  acc_q <= -acc_q;
                    end else if (neg_q) begin
                        {acc_q, sh_q} <= -{acc_q, sh_q};
                    end
                end
                default: ;
            endcase
        end
    end

    assign idle_o     = (state_q == MD_IDLE);
    assign busy_o     = (state_q == MD_MUL) || (state_q == MD_DIV) || (state_q == MD_FIX);
    assign done_o     = (state_q == MD_DONE);
    assign div_zero_o = (state_q == MD_DONE) && is_div_q && (mcand_q == '0);
    assign hi_o       = acc_q;
    assign lo_o       = sh_q;

endmodule

// File: rtl/alu_muldiv.sv
// Datapath ALU stage: registered single-cycle logic/arith ops plus an
// iterative signed mult/div unit feeding the HI/LO registers.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [3:0]       alu_con,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic             zero_q, zero_d, overflow_q, overflow_d;
    logic             done_q, done_d, div_zero_q, div_zero_d;

    logic             md_idle, md_busy, md_done, md_div_zero, accept, is_md;
    logic [WIDTH-1:0] md_hi, md_lo, res_c, sum_c, diff_c;
    logic             ovf_c;

    assign is_md  = is_muldiv(alu_con);
    // Issue only from IDLE: the DONE cycle drops busy but cannot take a new op.
    assign accept = valid_in && md_idle;

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv_iter (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (accept && is_md),
        .is_div_i   (alu_con == ALU_DIV),
        .a_i        (a),
        .b_i        (b),
        .idle_o     (md_idle),
        .busy_o     (md_busy),
        .done_o     (md_done),
        .div_zero_o (md_div_zero),
        .hi_o       (md_hi),
        .lo_o       (md_lo)
    );

    always_comb begin
        sum_c  = a + b;
        diff_c = a - b;
        res_c  = '0;
        ovf_c  = 1'b0;
        case (alu_con)
            ALU_AND: res_c = a & b;
            ALU_OR:  res_c = a | b;
            ALU_NOR: res_c = ~(a | b);
            ALU_ADD: begin
                res_c = sum_c;
                ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                res_c = diff_c;
                ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT: res_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: ;
        endcase
    end

    always_comb begin
        result_d   = result_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        if (md_done) begin
            done_d     = 1'b1;
            overflow_d = 1'b0;
            if (md_div_zero) begin
                div_zero_d = 1'b1;
            end else begin
                hi_d     = md_hi;
                lo_d     = md_lo;
                result_d = md_lo;
                zero_d   = (md_lo == '0);
            end
        end else if (accept && !is_md) begin
            result_d   = res_c;
            zero_d     = (res_c == '0);
            overflow_d = ovf_c;
            done_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
    assign busy     = md_busy;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized self-checking bench for alu_muldiv against an arithmetic
// reference model (64-bit signed math for mult/div, true-sum overflow).
module tb_alu_muldiv;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in;
    logic [3:0]    alu_con;
    logic [W-1:0]  a, b;
    logic [W-1:0]  result, hi, lo;
    logic          zero, overflow, busy, done, div_zero;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_res, exp_hi, exp_lo;
    logic         exp_zero;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .alu_con  (alu_con),
        .a        (a),
        .b        (b),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Overflow means the true signed result does not fit in W bits.
    function automatic void model_alu(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                      output logic [W-1:0] r, output logic o);
        longint sx, sy, t;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        t  = 0;
        o  = 1'b0;
        case (op)
            4'd0: r = x & y;
            4'd1: r = x | y;
            4'd4: r = ~(x | y);
            4'd2: begin t = sx + sy; r = t[W-1:0]; o = (t != longint'($signed(r))); end
            4'd6: begin t = sx - sy; r = t[W-1:0]; o = (t != longint'($signed(r))); end
            4'd7: r = (sx < sy) ? 1 : 0;
            default: r = '0;
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return W'($urandom_range(0, 20)) - 10;
            default: return $urandom;
        endcase
    endfunction

    task automatic check_idle_regs(input string tag);
        check_val({tag, "_hi"}, hi, exp_hi);
        check_val({tag, "_lo"}, lo, exp_lo);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_divz"}, div_zero, 0);
    endtask

    // Drives one single-cycle op for exactly one edge; valid_in is left high
    // so consecutive calls issue back-to-back.
    task automatic issue_single(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        logic         o;
        valid_in = 1'b1;
        alu_con  = op;
        a        = x;
        b        = y;
        model_alu(op, x, y, r, o);
        @(posedge clk);
        #1;
        exp_res  = r;
        exp_zero = (r == '0);
        check_val("single_result", result, r);
        check_val("single_zero", zero, exp_zero);
        check_val("single_ovf", overflow, o);
        check_val("single_done", done, 1);
        check_idle_regs("single");
    endtask

    task automatic run_muldiv(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input bit junk);
        longint sx, sy, p, q, rm;
        int     lat, busy_cnt;
        bit     dz;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        dz = (op == 4'b0101) && (y == '0);
        valid_in = 1'b1;
        alu_con  = op;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        check_val("md_busy_after_accept", busy, 1);
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        valid_in = junk;
        while (lat < 100) begin
            if (junk) begin
                alu_con = 4'b0010;
                a = $urandom;
                b = $urandom;
            end
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            busy_cnt += busy ? 1 : 0;
        end
        valid_in = 1'b0;
        check_val("md_done", done, 1);
        check_val("md_ovf", overflow, 0);
        check_val("md_busy_at_done", busy, 0);
        check_val("md_divzero", div_zero, dz);
        if (!dz) begin
            if (op == 4'b0011) begin
                p = sx * sy;
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end else begin
                q  = sx / sy;
                rm = sx % sy;
                exp_hi = rm[W-1:0];
                exp_lo = q[W-1:0];
            end
            exp_res  = exp_lo;
            exp_zero = (exp_lo == '0);
            check_val("md_latency", lat, W + 2);
            check_val("md_busy_cycles", busy_cnt, W + 1);
        end
        check_val("md_hi", hi, exp_hi);
        check_val("md_lo", lo, exp_lo);
        check_val("md_result", result, exp_res);
        check_val("md_zero", zero, exp_zero);
        @(posedge clk);
        #1;
        check_val("md_done_pulse", done, 0);
        check_val("md_result_hold", result, exp_res);
        check_idle_regs("md_after");
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_result"}, result, 0);
        check_val({tag, "_flags"}, {zero, overflow, busy, done, div_zero}, 0);
        check_val({tag, "_hi"}, hi, 0);
        check_val({tag, "_lo"}, lo, 0);
    endtask

    initial begin
        logic [3:0] op;
        int         done_seen;

        rst_n    = 1'b0;
        valid_in = 1'b0;
        alu_con  = '0;
        a        = '0;
        b        = '0;
        exp_res  = '0;
        exp_hi   = '0;
        exp_lo   = '0;
        exp_zero = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue_single(4'b0010, 32'h7FFF_FFFF, 32'h1);
        check_val("add_max_ovf", overflow, 1);
        issue_single(4'b0110, 32'd5, 32'd5);
        check_val("sub_eq_zero", zero, 1);
        issue_single(4'b0111, 32'hFFFF_FFFF, 32'h1);
        check_val("slt_neg", result, 1);
        issue_single(4'b1010, 32'h1234_5678, 32'h9ABC_DEF0);
        check_val("code_1010_zero", zero, 1);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check_val("idle_no_done", done, 0);

        run_muldiv(4'b0011, -32'sd3, 32'sd7, 1'b0);
        check_val("mult_hi", hi, 32'hFFFF_FFFF);
        check_val("mult_lo", lo, 32'hFFFF_FFEB);
        run_muldiv(4'b0101, -32'sd7, 32'sd2, 1'b0);
        check_val("div_lo", lo, 32'hFFFF_FFFD);
        check_val("div_hi", hi, 32'hFFFF_FFFF);
        run_muldiv(4'b0101, 32'd99, 32'd0, 1'b0);
        run_muldiv(4'b0011, 32'd123456, -32'sd789, 1'b1);
        run_muldiv(4'b0101, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_val("div_wrap_lo", lo, 32'h8000_0000);
        check_val("div_wrap_hi", hi, 0);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'b0011 || op == 4'b0101) op = 4'b0110;
            issue_single(op, rnd_operand(), rnd_operand());
        end
        valid_in = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_muldiv(($urandom_range(0, 1) != 0) ? 4'b0011 : 4'b0101,
                       rnd_operand(), rnd_operand(), bit'($urandom_range(0, 1)));
        end

        valid_in = 1'b1;
        alu_con  = 4'b0011;
        a        = 32'd1000;
        b        = 32'd77;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check_all_zero("rst_mid");
        exp_res  = '0;
        exp_hi   = '0;
        exp_lo   = '0;
        exp_zero = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check_val("rst_mid_no_done", done_seen, 0);
        check_all_zero("rst_mid_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
